pattern_stream_ctrl: RTL and testbench

PATTERN_STREAM_CTRL -- requirements
Module: pattern_stream_ctrl

---
 rtl/pattern_stream_pkg.sv | 20 ++
 rtl/pattern_stream_gap_timer.sv | 39 +++
 rtl/pattern_stream_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pattern_stream_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_stream_pkg.sv
// Shared definitions for the pattern stream controller: default widths and
// the sequencer state encoding.
package pattern_stream_pkg;

    // Default width of the row and gap counters.
    localparam int unsigned CNT_W_DEF = 16;

    // Default width of the FIFO read-side word count.
    localparam int unsigned LVL_W_DEF = 13;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        STREAM    = 3'd2,
        GAP       = 3'd3,
        DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/pattern_stream_gap_timer.sv
// Loadable down-counter with a zero flag, used to time the idle gap
// between patterns. A load takes priority over a decrement, and the
// counter saturates at zero.
module gap_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, otherwise count down until zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pattern_stream_ctrl.sv
// Pattern stream controller: waits until the output FIFO holds a full
// pattern, streams it out one word per cycle (stalling while the FIFO is
// empty), idles for a programmable gap and repeats for num_pat patterns.
module pattern_stream_ctrl
    import pattern_stream_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned LVL_W = LVL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      num_pat,
    input  logic [CNT_W-1:0] rows_per_pat,
    input  logic [CNT_W-1:0] gap_cycles,
    input  logic             fifo_empty,
    input  logic [LVL_W-1:0] fifo_rd_count,
    output logic             stream_en,
    output logic             pat_start,
    output logic [31:0]      pat_cnt,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic             cfg_err
);

    // Common width for comparing the FIFO level against the row count.
    localparam int unsigned CMP_W = (CNT_W > LVL_W) ? CNT_W : LVL_W;

    state_e           state_q,     state_d;
    logic [31:0]      num_pat_q,   num_pat_d;
    logic [CNT_W-1:0] rows_q,      rows_d;
    logic [CNT_W-1:0] gap_q,       gap_d;
    logic [CNT_W-1:0] row_cnt_q,   row_cnt_d;
    logic [31:0]      pat_cnt_q,   pat_cnt_d;
    logic             underflow_q, underflow_d;
    logic             cfg_err_q,   cfg_err_d;

    logic             stream_rd;
    logic             last_read;
    logic [31:0]      pat_cnt_inc;
    logic [CMP_W-1:0] lvl_ext;
    logic [CMP_W-1:0] rows_ext;
    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;

    // A word is read whenever we are streaming and the FIFO has data.
    assign stream_rd   = (state_q == STREAM) && !fifo_empty;
    assign last_read   = stream_rd && (row_cnt_q == (rows_q - 1'b1));
    assign pat_cnt_inc = pat_cnt_q + 32'd1;
    assign lvl_ext     = CMP_W'(fifo_rd_count);
    assign rows_ext    = CMP_W'(rows_q);

    gap_timer #(
        .W(CNT_W)
    ) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (gap_q - 1'b1),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    // Next-state, counter and flag logic; abort overrides everything else
    // and leaves the counters and flags untouched.
    always_comb begin
        state_d     = state_q;
        num_pat_d   = num_pat_q;
        rows_d      = rows_q;
        gap_d       = gap_q;
        row_cnt_d   = row_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        underflow_d = underflow_q;
        cfg_err_d   = cfg_err_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (rows_per_pat == '0) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            num_pat_d   = num_pat;
                            rows_d      = rows_per_pat;
                            gap_d       = gap_cycles;
                            row_cnt_d   = '0;
                            pat_cnt_d   = '0;
                            underflow_d = 1'b0;
                            cfg_err_d   = 1'b0;
                            state_d     = (num_pat == '0) ? DONE : WAIT_DATA;
                        end
                    end
                end

                WAIT_DATA: begin
                    if (lvl_ext >= rows_ext) begin
                        row_cnt_d = '0;
                        state_d   = STREAM;
                    end
                end

                STREAM: begin
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                    end else if (last_read) begin
                        pat_cnt_d = pat_cnt_inc;
                        row_cnt_d = '0;
                        if (pat_cnt_inc == num_pat_q) begin
                            state_d = DONE;
                        end else if (gap_q == '0) begin
                            state_d = WAIT_DATA;
                        end else begin
                            timer_load = 1'b1;
                            state_d    = GAP;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end

                GAP: begin
                    if (timer_zero) begin
                        state_d = WAIT_DATA;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, latched configuration, counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            num_pat_q   <= '0;
            rows_q      <= '0;
            gap_q       <= '0;
            row_cnt_q   <= '0;
            pat_cnt_q   <= '0;
            underflow_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_pat_q   <= num_pat_d;
            rows_q      <= rows_d;
            gap_q       <= gap_d;
            row_cnt_q   <= row_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            underflow_q <= underflow_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // stream_en follows the state register directly, so an asynchronous
    // reset drops it immediately.
    assign stream_en = stream_rd;
    assign pat_start = stream_rd && (row_cnt_q == '0);
    assign pat_cnt   = pat_cnt_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign underflow = underflow_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Scoreboard bench for pattern_stream_ctrl: each sequence pushes its
// expected read and done events, and a monitor pops and compares them
// whenever the DUT reads a word or pulses done.
module tb_pattern_stream_ctrl;

    localparam int CNT_W = 16;
    localparam int LVL_W = 13;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic [31:0]      num_pat;
    logic [CNT_W-1:0] rows_per_pat;
    logic [CNT_W-1:0] gap_cycles;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_rd_count;
    logic             stream_en;
    logic             pat_start;
    logic [31:0]      pat_cnt;
    logic             busy;
    logic             done;
    logic             underflow;
    logic             cfg_err;

    typedef struct {
        bit          isDone;
        bit          patStart;
        logic [31:0] patCnt;
        int          cyc;
    } evt_t;

    evt_t expQ[$];
    int   total  = 0;
    int   bad    = 0;
    int   cycNow = 0;
    int   t0     = 0;

    pattern_stream_ctrl #(
        .CNT_W(CNT_W),
        .LVL_W(LVL_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_pat      (num_pat),
        .rows_per_pat (rows_per_pat),
        .gap_cycles   (gap_cycles),
        .fifo_empty   (fifo_empty),
        .fifo_rd_count(fifo_rd_count),
        .stream_en    (stream_en),
        .pat_start    (pat_start),
        .pat_cnt      (pat_cnt),
        .busy         (busy),
        .done         (done),
        .underflow    (underflow),
        .cfg_err      (cfg_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to time-stamp events.
    always @(posedge clk) cycNow <= cycNow + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal schedule: pattern p row r is read at first + p*(rows+gap+1) + r
    // (gap idle cycles plus one WAIT_DATA cycle between patterns).
    task automatic pushReads(input int rows, input int gap, input int first, input int count);
        for (int k = 0; k < count; k++) begin
            evt_t e;
            int   p;
            int   r;
            p          = k / rows;
            r          = k % rows;
            e.isDone   = 1'b0;
            e.patStart = (r == 0);
            e.patCnt   = p;
            e.cyc      = (first < 0) ? -1 : first + p * (rows + gap + 1) + r;
            expQ.push_back(e);
        end
    endtask

    task automatic pushDone(input logic [31:0] n, input int cyc);
        evt_t e;
        e.isDone   = 1'b1;
        e.patStart = 1'b0;
        e.patCnt   = n;
        e.cyc      = cyc;
        expQ.push_back(e);
    endtask

    // Pulse start with the given configuration; call at posedge+1.
    task automatic applyStimulus(input logic [31:0] n, input int rows, input int gap);
        num_pat      = n;
        rows_per_pat = rows[CNT_W-1:0];
        gap_cycles   = gap[CNT_W-1:0];
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cycNow;
    endtask

    task automatic toCycle(input int k);
        while ((cycNow - t0) < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare an expected event on every read or done.
    always @(negedge clk) begin
        evt_t e;
        if (!reset) begin
            if (!stream_en) checkOutput("pat_start_no_read", pat_start, 0);
            if (stream_en || done) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious_event: got stream_en=%0b done=%0b, expected none (t=%0t)",
                             stream_en, done, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event_kind", done, e.isDone);
                    if (!e.isDone) checkOutput("pat_start", pat_start, e.patStart);
                    checkOutput("pat_cnt_at_event", pat_cnt, e.patCnt);
                    if (e.cyc >= 0) checkOutput("event_cycle", cycNow - t0, e.cyc);
                end
            end
        end
    end

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized sequences.
    initial begin
        int n;
        int rows;
        int gap;
        int r32;

        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        num_pat       = '0;
        rows_per_pat  = '0;
        gap_cycles    = '0;
        fifo_empty    = 1'b0;
        fifo_rd_count = '1;

        repeat (2) @(negedge clk);
        checkOutput("rst_stream_en", stream_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pat_start", pat_start, 0);
        checkOutput("rst_underflow", underflow, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_pat_cnt", pat_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] 3 patterns x 4 rows, gap 2, FIFO always ready");
        pushReads(4, 2, 1, 12);
        pushDone(3, 19);
        applyStimulus(3, 4, 2);
        waitIdle(200);
        checkOutput("a_pat_cnt", pat_cnt, 3);
        checkOutput("a_underflow", underflow, 0);
        checkOutput("a_drained", expQ.size(), 0);

        $display("[TB] 1 pattern x 8 rows, FIFO empty 3 cycles after 2nd read");
        for (int r = 0; r < 8; r++) begin
            evt_t e;
            e.isDone   = 1'b0;
            e.patStart = (r == 0);
            e.patCnt   = 0;
            e.cyc      = (r < 2) ? 1 + r : 4 + r;
            expQ.push_back(e);
        end
        pushDone(1, 12);
        applyStimulus(1, 8, 0);
        toCycle(3);
        fifo_empty = 1'b1;
        toCycle(6);
        fifo_empty = 1'b0;
        waitIdle(200);
        checkOutput("b_underflow", underflow, 1);
        checkOutput("b_pat_cnt", pat_cnt, 1);
        checkOutput("b_drained", expQ.size(), 0);

        $display("[TB] num_pat 0");
        pushDone(0, 0);
        applyStimulus(0, 4, 0);
        @(negedge clk);
        checkOutput("c_busy_first", busy, 1);
        checkOutput("c_underflow_cleared", underflow, 0);
        @(negedge clk);
        checkOutput("c_busy_after", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("c_drained", expQ.size(), 0);

        $display("[TB] rows 0 rejected, then valid start");
        applyStimulus(1, 0, 0);
        @(negedge clk);
        checkOutput("d_cfg_err_set", cfg_err, 1);
        checkOutput("d_busy_low", busy, 0);
        @(posedge clk);
        #1;
        pushReads(2, 0, 1, 2);
        pushDone(1, 3);
        applyStimulus(1, 2, 0);
        @(negedge clk);
        checkOutput("d_cfg_err_cleared", cfg_err, 0);
        checkOutput("d_busy_high", busy, 1);
        waitIdle(200);
        checkOutput("d_drained", expQ.size(), 0);

        $display("[TB] abort during 2nd of 5 patterns");
        pushReads(3, 1, 1, 5);
        applyStimulus(5, 3, 1);
        toCycle(7);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("e_busy", busy, 0);
        checkOutput("e_stream_en", stream_en, 0);
        checkOutput("e_pat_cnt", pat_cnt, 1);
        checkOutput("e_done", done, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("e_drained", expQ.size(), 0);

        $display("[TB] FIFO level one short, then sufficient");
        fifo_rd_count = 13'd3;
        pushReads(4, 0, 6, 4);
        pushDone(1, 10);
        applyStimulus(1, 4, 0);
        toCycle(5);
        fifo_rd_count = 13'd4;
        waitIdle(200);
        checkOutput("f_drained", expQ.size(), 0);

        $display("[TB] num_pat all ones, abort after 3 patterns");
        fifo_rd_count = '1;
        pushReads(2, 0, 1, 6);
        applyStimulus(32'hFFFF_FFFF, 2, 0);
        toCycle(9);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("g_busy", busy, 0);
        checkOutput("g_pat_cnt", pat_cnt, 3);
        @(posedge clk);
        #1;
        checkOutput("g_drained", expQ.size(), 0);

        $display("[TB] asynchronous reset mid-stream");
        pushReads(8, 0, 1, 2);
        applyStimulus(2, 8, 0);
        toCycle(3);
        checkOutput("h_stream_before_reset", stream_en, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("h_stream_en_async", stream_en, 0);
        checkOutput("h_busy_async", busy, 0);
        checkOutput("h_pat_start_async", pat_start, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("h_drained", expQ.size(), 0);
        @(posedge clk);
        #1;

        $display("[TB] randomized sequences");
        for (int it = 0; it < 8; it++) begin
            n    = $urandom_range(1, 4);
            rows = $urandom_range(1, 5);
            gap  = $urandom_range(0, 3);
            pushReads(rows, gap, -1, n * rows);
            pushDone(n, -1);
            applyStimulus(n, rows, gap);
            for (int c = 0; (c < 2000) && busy; c++) begin
                fifo_empty    = ($urandom_range(0, 3) == 0);
                r32           = $urandom_range(0, rows + 2);
                fifo_rd_count = r32[LVL_W-1:0];
                if (busy && !done && ($urandom_range(0, 9) == 0)) begin
                    start        = 1'b1;
                    num_pat      = $urandom;
                    r32          = $urandom_range(0, 3);
                    rows_per_pat = r32[CNT_W-1:0];
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            start      = 1'b0;
            fifo_empty = 1'b0;
            checkOutput("rand_idle", busy, 0);
            checkOutput("rand_pat_cnt", pat_cnt, n);
            checkOutput("rand_drained", expQ.size(), 0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
